// File: rtl/stack_sequencer.sv
// ---------------------------------------------------------------------------
// stack_sequencer
//
// Purpose: command sequencer for a word-wide stack built from WIDTH
// shift_register-style bit-planes of DEPTH entries each. It accepts one
// stack command at a time and tracks how many entries are live. Legal
// commands drive one shared STACK_MODE_* code and a per-plane d bit for
// exactly one cycle. Illegal commands are rejected and leave the stack
// untouched.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst_n      in   synchronous active-low reset
//   cmd_valid  in   command offered
//   cmd_op     in   [2:0] 0 NOP, 1 PUSH, 2 POP, 3 SWAP, 4 ROLL2, 5 DUP,
//                   6 CLEAR, 7 reserved
//   cmd_data   in   [WIDTH-1:0] operand for PUSH / ROLL2
//   top_in     in   [WIDTH-1:0] current top word, used by DUP
//   cmd_ready  out  high only in IDLE (and not in the first cycle after reset)
//   stk_mode   out  [2:0] registered STACK_MODE_* code for all bit-planes
//   stk_d      out  [WIDTH-1:0] registered per-plane d input
//   depth      out  live entry count
//   full       out  depth == DEPTH
//   empty      out  depth == 0
//   done       out  one-cycle pulse per completed or rejected command
//   err        out  sticky rejection flag
//
// Build option: define STACK_SEQUENCER_ERR_EN to enable the sticky err flag.
// Without it, err is tied low and rejection behaves the same in every
// other respect.
// ---------------------------------------------------------------------------
module stack_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    input  logic [2:0]                   cmd_op,
    input  logic [WIDTH-1:0]             cmd_data,
    input  logic [WIDTH-1:0]             top_in,
    output logic                         cmd_ready,
    output logic [2:0]                   stk_mode,
    output logic [WIDTH-1:0]             stk_d,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         full,
    output logic                         empty,
    output logic                         done,
    output logic                         err
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] DEPTH_W = DW'(DEPTH);

    // Opcodes
    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_PUSH  = 3'd1;
    localparam logic [2:0] OP_POP   = 3'd2;
    localparam logic [2:0] OP_SWAP  = 3'd3;
    localparam logic [2:0] OP_ROLL2 = 3'd4;
    localparam logic [2:0] OP_DUP   = 3'd5;
    localparam logic [2:0] OP_CLEAR = 3'd6;

    // Bit-plane mode codes
    localparam logic [2:0] STACK_MODE_IDLE  = 3'd0;
    localparam logic [2:0] STACK_MODE_PUSH  = 3'd1;
    localparam logic [2:0] STACK_MODE_POP   = 3'd2;
    localparam logic [2:0] STACK_MODE_SWAP  = 3'd3;
    localparam logic [2:0] STACK_MODE_ROLL2 = 3'd4;
    localparam logic [2:0] STACK_MODE_RESET = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state, nxt;
    logic              rst_hold;
    logic              accept;
    logic              legal;
    logic              two_plus;
    logic [2:0]        mode_sel;
    logic [WIDTH-1:0]  d_sel;
    logic [2:0]        op_p0;

    assign full     = (depth == DEPTH_W);
    assign empty    = (depth == '0);
    // Comparing with 1 (rather than >= 2) stays correct when DW is 1 bit.
    assign two_plus = (depth > DW'(1));
    // rst_hold keeps the port closed for the cycle in which the bit-planes
    // still see STACK_MODE_RESET after reset is released.
    assign cmd_ready = (state == S_IDLE) && !rst_hold;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    // Command decode and next state
    always_comb begin
        accept   = cmd_valid && cmd_ready;
        legal    = 1'b0;
        mode_sel = STACK_MODE_IDLE;
        d_sel    = '0;
        case (cmd_op)
            OP_PUSH:  begin legal = !full;    mode_sel = STACK_MODE_PUSH;  d_sel = cmd_data; end
            OP_POP:   begin legal = !empty;   mode_sel = STACK_MODE_POP;   end
            OP_SWAP:  begin legal = two_plus; mode_sel = STACK_MODE_SWAP;  end
            OP_ROLL2: begin legal = two_plus; mode_sel = STACK_MODE_ROLL2; d_sel = cmd_data; end
            OP_DUP:   begin legal = !full;    mode_sel = STACK_MODE_PUSH;  d_sel = top_in;   end
            OP_CLEAR: begin legal = 1'b1;     mode_sel = STACK_MODE_RESET; end
            default:  legal = 1'b0;   // NOP and reserved take the short path
        endcase

        nxt = state;
        case (state)
            S_IDLE:  if (accept) nxt = legal ? S_ISSUE : S_DONE;
            S_ISSUE: nxt = S_DONE;
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Registered outputs and depth. stk_mode/stk_d are loaded on acceptance
    // so that they are valid for exactly the ISSUE cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stk_mode <= STACK_MODE_RESET;
            stk_d    <= '0;
            done     <= 1'b0;
            depth    <= '0;
            rst_hold <= 1'b1;
        end else begin
            rst_hold <= 1'b0;
            done     <= (nxt == S_DONE);
            if (accept && legal) begin
                stk_mode <= mode_sel;
                stk_d    <= d_sel;
            end else begin
                stk_mode <= STACK_MODE_IDLE;
                stk_d    <= '0;
            end
            if (state == S_ISSUE) begin
                case (op_p0)
                    OP_PUSH, OP_DUP:  depth <= depth + DW'(1);
                    OP_POP, OP_ROLL2: depth <= depth - DW'(1);
                    OP_CLEAR:         depth <= '0;
                    default:          depth <= depth;
                endcase
            end
        end
    end

    // Opcode held for the depth update at the ISSUE->DONE edge
    always_ff @(posedge clk) begin
        if (accept) op_p0 <= cmd_op;
    end

`ifdef STACK_SEQUENCER_ERR_EN
    logic reject;
    assign reject = accept && !legal && (cmd_op != OP_NOP);

    always_ff @(posedge clk) begin
        if (!rst_n)
            err <= 1'b0;
        else if (reject)
            err <= 1'b1;
        else if ((state == S_ISSUE) && (op_p0 == OP_CLEAR))
            err <= 1'b0;
    end
`else
    assign err = 1'b0;
`endif

endmodule
